// File: rtl/alu_multicycle.sv
// alu_multicycle: execute unit for the MIPS pipeline.
// Single-cycle ALU ops return a registered result one cycle after issue.
// MULT/MULTU/DIV/DIVU iterate one bit per cycle on operand magnitudes,
// apply a sign correction in a final cycle, then write HI/LO.
module alu_multicycle #(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_ADDU  = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_LUI   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_SRL   = 5'd12;
  localparam logic [4:0] OP_SLL   = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_DIV   = 5'd18;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic                 busy_r;
  logic [SHW-1:0]       cnt_r;
  logic [2*WIDTH-1:0]   acc_r;      // {partial product} or {remainder, quotient}
  logic [WIDTH-1:0]     dvs_r;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     a_r;        // original dividend, reported on divide by zero
  logic                 is_div_r;
  logic                 neg_q_r;    // negate product / quotient
  logic                 neg_rem_r;  // negate remainder
  logic                 dz_r;       // divide by zero

  logic                 out_valid_r;
  logic [WIDTH-1:0]     r_r;
  logic                 zero_r;
  logic                 ovf_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 accept_s;
  logic                 is_multi_s;
  logic                 signed_op_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_ovf_s;
  logic [WIDTH-1:0]     sum_s;
  logic [WIDTH-1:0]     diff_s;

  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       rem_sh_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   div_next_s;

  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     fix_hi_s;
  logic [WIDTH-1:0]     fix_lo_s;

  assign accept_s    = in_valid && !busy_r;
  assign is_multi_s  = (op[4:2] == 3'b100);
  assign signed_op_s = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg_s     = signed_op_s && a[WIDTH-1];
  assign b_neg_s     = signed_op_s && b[WIDTH-1];
  assign a_mag_s     = a_neg_s ? (~a + WIDTH'(1)) : a;
  assign b_mag_s     = b_neg_s ? (~b + WIDTH'(1)) : b;
  assign sum_s       = a + b;
  assign diff_s      = a - b;

  assign in_ready  = !busy_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign r         = r_r;
  assign zero      = zero_r;
  assign overflow  = ovf_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

  // Single-cycle ALU result and signed-overflow flag for the presented op.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res_s = sum_s;
      OP_SUBU: alu_res_s = diff_s;
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOR:  alu_res_s = ~(a | b);
      OP_LUI:  alu_res_s = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  alu_res_s = WIDTH'($signed(b) >>> a[SHW-1:0]);
      OP_SRL:  alu_res_s = b >> a[SHW-1:0];
      OP_SLL:  alu_res_s = b << a[SHW-1:0];
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step and one restoring-divide step on acc_r.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
    div_ge_s   = (rem_sh_s >= {1'b0, dvs_r});
    // The true difference is below the divisor, so WIDTH bits hold it exactly.
    div_rem_s  = rem_sh_s[WIDTH-1:0] - dvs_r;
    if (div_ge_s) begin
      div_next_s = {div_rem_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and special-case handling of the iterated result.
  always_comb begin
    prod_s   = neg_q_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (dz_r) begin
        fix_lo_s = {WIDTH{1'b1}};
        fix_hi_s = a_r;
      end else begin
        fix_lo_s = neg_q_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
        fix_hi_s = neg_rem_r ? (~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1))
                             : acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state logic: IDLE -> ITER on a mult/div issue, WIDTH steps, one FIX cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_multi_s) begin
          state_nx_s = ITER;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == LAST_ITER) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = ITER;
        end
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
    end
  end

  // Iteration datapath: operand capture on issue, one step per ITER cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {SHW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
    end else if (state_r == IDLE) begin
      if (accept_s && is_multi_s) begin
        cnt_r     <= {SHW{1'b0}};
        is_div_r  <= op[1];
        a_r       <= a;
        neg_q_r   <= a_neg_s ^ b_neg_s;
        neg_rem_r <= a_neg_s;
        dz_r      <= (b == {WIDTH{1'b0}});
        if (op[1]) begin
          acc_r <= {{WIDTH{1'b0}}, a_mag_s};
          dvs_r <= b_mag_s;
        end else begin
          acc_r <= {{WIDTH{1'b0}}, b_mag_s};
          dvs_r <= a_mag_s;
        end
      end
    end else if (state_r == ITER) begin
      acc_r <= is_div_r ? div_next_s : mul_next_s;
      cnt_r <= cnt_r + SHW'(1);
    end
  end

  // Result registers: single-cycle results at issue, HI/LO at mult/div completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      r_r         <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      if (accept_s && !is_multi_s) begin
        out_valid_r <= 1'b1;
        r_r         <= alu_res_s;
        zero_r      <= (alu_res_s == {WIDTH{1'b0}});
        ovf_r       <= alu_ovf_s;
      end else if (state_r == FIX) begin
        out_valid_r <= 1'b1;
        r_r         <= fix_lo_s;
        zero_r      <= (fix_lo_s == {WIDTH{1'b0}});
        ovf_r       <= 1'b0;
        hi_r        <= fix_hi_s;
        lo_r        <= fix_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [4:0]  op32 = 5'd0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic        out_valid32, zero32, ovf32, busy32;
  logic [31:0] r32, hi32, lo32;

  // 8-bit instance
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [4:0]  op8 = 5'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        out_valid8, zero8, ovf8, busy8;
  logic [7:0]  r8, hi8, lo8;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .op(op32), .a(a32), .b(b32), .out_valid(out_valid32), .r(r32),
    .zero(zero32), .overflow(ovf32), .hi(hi32), .lo(lo32), .busy(busy32));

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .r(r8),
    .zero(zero8), .overflow(ovf8), .hi(hi8), .lo(lo8), .busy(busy8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Issue one op on the 32-bit unit (called #1 after a posedge) and wait for its pulse.
  task automatic do_op32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rr, output logic zz, output logic vv,
                         output int lat);
    op32 = o; a32 = x; b32 = y; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rr = r32; zz = zero32; vv = ovf32;
  endtask

  // Reference model from the architectural rules (64-bit arithmetic).
  task automatic model32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] mhi, inout logic [31:0] mlo,
                         output logic [31:0] er, output logic eo, output int elat);
    longint s;
    logic [63:0] p;
    logic signed [31:0] sx, sy;
    sx = x; sy = y;
    er = 32'd0; eo = 1'b0; elat = 1;
    case (o)
      5'd0: begin s = longint'(sx) + longint'(sy); er = x + y;
                  eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd1: begin s = longint'(sx) - longint'(sy); er = x - y;
                  eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd2: er = x + y;
      5'd3: er = x - y;
      5'd4: er = x & y;
      5'd5: er = x | y;
      5'd6: er = x ^ y;
      5'd7: er = ~(x | y);
      5'd8: er = {y[15:0], 16'h0000};
      5'd9: er = (sx < sy) ? 32'd1 : 32'd0;
      5'd10: er = (x < y) ? 32'd1 : 32'd0;
      5'd11: er = sy >>> x[4:0];
      5'd12: er = y >> x[4:0];
      5'd13: er = y << x[4:0];
      5'd16: begin p = longint'(sx) * longint'(sy); mhi = p[63:32]; mlo = p[31:0];
                   er = mlo; elat = 34; end
      5'd17: begin p = {32'd0, x} * {32'd0, y}; mhi = p[63:32]; mlo = p[31:0];
                   er = mlo; elat = 34; end
      5'd18: begin
        if (y == 32'd0) begin mlo = 32'hFFFFFFFF; mhi = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin mlo = 32'h80000000; mhi = 32'd0; end
        else begin mlo = sx / sy; mhi = sx % sy; end
        er = mlo; elat = 34;
      end
      5'd19: begin
        if (y == 32'd0) begin mlo = 32'hFFFFFFFF; mhi = x; end
        else begin mlo = x / y; mhi = x % y; end
        er = mlo; elat = 34;
      end
      default: er = 32'd0;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      5: return 32'(-$urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] er;
    logic        eo, ez;
    logic        chk_hl;
    logic [31:0] ehi, elo;
    int          elat;
  } vec_t;

  vec_t vt[17];

  initial begin
    logic [31:0] rr, mhi, mlo, er;
    logic zz, vv, eo;
    int lat, elat, cyc, bad, pulses;

    vt[0]  = '{5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[1]  = '{5'd2,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[2]  = '{5'd1,  32'h5,        32'h5,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1};
    vt[3]  = '{5'd11, 32'h4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[4]  = '{5'd12, 32'h4,        32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[5]  = '{5'd13, 32'h21,       32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[6]  = '{5'd9,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[7]  = '{5'd10, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1};
    vt[8]  = '{5'd8,  32'h0,        32'h1234ABCD, 32'hABCD0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[9]  = '{5'd7,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[10] = '{5'd3,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[11] = '{5'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1};
    vt[12] = '{5'd16, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vt[13] = '{5'd18, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vt[14] = '{5'd19, 32'h9,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h9,        32'hFFFFFFFF, 34};
    vt[15] = '{5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h0,        32'h80000000, 34};
    vt[16] = '{5'd14, 32'h5,        32'h5,        32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h80000000, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_ready", {63'd0, in_ready32}, 64'd1);
    chk("rst_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_r", {32'd0, r32}, 64'd0);
    chk("rst_hilo", {hi32, lo32}, 64'd0);
    chk("rst_flags", {62'd0, zero32, ovf32}, 64'd0);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      do_op32(vt[i].op, vt[i].a, vt[i].b, rr, zz, vv, lat);
      chk($sformatf("tab%0d_lat", i), 64'(lat), 64'(vt[i].elat));
      chk($sformatf("tab%0d_r", i), {32'd0, rr}, {32'd0, vt[i].er});
      chk($sformatf("tab%0d_zero", i), {63'd0, zz}, {63'd0, vt[i].ez});
      chk($sformatf("tab%0d_ovf", i), {63'd0, vv}, {63'd0, vt[i].eo});
      if (vt[i].chk_hl) begin
        chk($sformatf("tab%0d_hi", i), {32'd0, hi32}, {32'd0, vt[i].ehi});
        chk($sformatf("tab%0d_lo", i), {32'd0, lo32}, {32'd0, vt[i].elo});
      end
    end

    // MULT with in_valid held during busy: ignored, in_ready low for 33 cycles
    op32 = 5'd16; a32 = 32'hFFFFFFFD; b32 = 32'd7; in_valid32 = 1'b1;
    @(posedge clk); #1;
    op32 = 5'd0; a32 = 32'd1; b32 = 32'd1;
    cyc = 1; bad = 0;
    while (!out_valid32 && cyc < 100) begin
      if (in_ready32) bad++;
      if (cyc == 20) in_valid32 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("mult_ready_low", 64'(bad), 64'd0);
    chk("mult_lat", 64'(cyc), 64'd34);
    chk("mult_hilo", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mult_r", {32'd0, r32}, 64'hFFFFFFEB);
    chk("mult_done_ready", {62'd0, in_ready32, busy32}, 64'd2);
    @(posedge clk); #1;
    chk("mult_pulse_once", {63'd0, out_valid32}, 64'd0);

    // Reset in cycle N+10 of a DIVU
    op32 = 5'd19; a32 = 32'd100; b32 = 32'd7; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy_ready", {62'd0, busy32, in_ready32}, 64'd1);
    chk("midrst_valid", {63'd0, out_valid32}, 64'd0);
    chk("midrst_r", {32'd0, r32}, 64'd0);
    chk("midrst_hilo", {hi32, lo32}, 64'd0);
    chk("midrst_flags", {62'd0, zero32, ovf32}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (out_valid32) pulses++;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'd0);
    do_op32(5'd0, 32'd1, 32'd2, rr, zz, vv, lat);
    chk("postrst_add_lat", 64'(lat), 64'd1);
    chk("postrst_add_r", {32'd0, rr}, 64'd3);

    // Randomized ops against the reference model
    mhi = 32'd0; mlo = 32'd0;
    for (int n = 0; n < 80; n++) begin
      logic [4:0] o;
      logic [31:0] x, y;
      o = 5'($urandom_range(0, 31));
      if (n % 3 == 0) o = 5'($urandom_range(16, 19));
      x = pick(); y = pick();
      model32(o, x, y, mhi, mlo, er, eo, elat);
      do_op32(o, x, y, rr, zz, vv, lat);
      chk($sformatf("rnd%0d_op%0d_lat", n, o), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d_op%0d_r a=%h b=%h", n, o, x, y), {32'd0, rr}, {32'd0, er});
      chk($sformatf("rnd%0d_op%0d_flags", n, o), {62'd0, zz, vv}, {62'd0, (er == 32'd0), eo});
      chk($sformatf("rnd%0d_op%0d_hilo", n, o), {hi32, lo32}, {mhi, mlo});
    end

    // WIDTH=8: MULTU 0xFF*0xFF
    op8 = 5'd17; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8_multu_lat", 64'(cyc), 64'd10);
    chk("w8_multu_hilo", {48'd0, hi8, lo8}, 64'hFE01);
    chk("w8_multu_r", {56'd0, r8}, 64'h01);

    // WIDTH=8: back-to-back AND, OR, XOR
    a8 = 8'hC3; b8 = 8'h5A; op8 = 5'd4; in_valid8 = 1'b1;
    @(posedge clk); #1;
    op8 = 5'd5;
    chk("w8_and", {55'd0, out_valid8, r8}, {55'd0, 1'b1, 8'h42});
    @(posedge clk); #1;
    op8 = 5'd6;
    chk("w8_or", {55'd0, out_valid8, r8}, {55'd0, 1'b1, 8'hDB});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8_xor", {55'd0, out_valid8, r8}, {55'd0, 1'b1, 8'h99});
    @(posedge clk); #1;
    chk("w8_idle", {63'd0, out_valid8}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised next-generation execute unit for the MIPS pipeline.
- Single-cycle ops return a registered result one cycle after issue.
- Iterative MULT/MULTU/DIV/DIVU run for several cycles and write HI/LO.
- Valid/ready issue handshake; the pipeline stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width; power of 2, >=8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op/a/b valid.
- in_ready  out  1  unit can accept; equals !busy.
- op  in  5  operation code (see Behaviour).
- a  in  WIDTH  operand A; a[SHW-1:0] is the shift amount.
- b  in  WIDTH  operand B; shifted operand.
- out_valid  out  1  one-cycle pulse; r/zero/overflow valid.
- r  out  WIDTH  result; for MULT/DIV ops equals new lo.
- zero  out  1  r==0 for the pulsed result.
- overflow  out  1  signed overflow, ADD/SUB only.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async, any time, including mid-op): state IDLE; busy=0, in_ready=1, out_valid=0, r=0, zero=0, overflow=0, hi=0, lo=0, iteration counter=0. An in-flight op is discarded with no out_valid.
- Accept on a rising edge with in_valid && in_ready. Operands are captured at that edge. Inputs are ignored while busy.
- Single-cycle ops (accepted in cycle N): r, zero and overflow are registered and out_valid=1 in cycle N+1. Back-to-back issue is allowed every cycle.
- Opcodes 0-13:
  - 0 ADD and 1 SUB: wrap-around result; overflow set on signed overflow.
  - 2 ADDU and 3 SUBU: overflow=0.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 LUI: b[WIDTH/2-1:0] placed in the upper half, lower half zero.
  - 9 SLT: signed compare, r=1 or 0. 10 SLTU: unsigned compare.
  - 11 SRA: b >>> a[SHW-1:0], sign fill. 12 SRL: b >> a[SHW-1:0]. 13 SLL: b << a[SHW-1:0]. Upper bits of a are ignored.
- Opcodes 16-19: 16 MULT (signed), 17 MULTU, 18 DIV (signed), 19 DIVU.
- Undefined opcodes: r=0, overflow=0, out_valid still pulses at N+1, hi/lo unchanged.
- FSM states IDLE, ITER, FIX:
  - IDLE -> ITER on accept of a mult/div op. busy=1 from cycle N+1. Operand magnitudes are taken for signed ops.
  - ITER: one shift-add (multiply) or restoring-subtract (divide) step per cycle; WIDTH cycles, counter 0..WIDTH-1.
  - ITER -> FIX: sign correction. Product is negated if operand signs differ. Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - FIX -> IDLE: hi/lo written. Multiply: hi = upper half, lo = lower half of the 2*WIDTH product. Divide: lo = quotient, hi = remainder. r=lo.
  - out_valid=1 and busy=0 in cycle N+WIDTH+2. A new op may be accepted in that same cycle.
- Divide by zero (DIV or DIVU): lo = all ones, hi = a, no sign fix. Full latency still applies.
- DIV with most-negative / -1: lo = most-negative value, hi=0.
- hi/lo change only at the completion of a mult/div op.
- out_valid is a pulse with no backpressure.
- zero and overflow are held between pulses; downstream must only sample them while out_valid=1.

Test Plan:
- WIDTH=32. ADD a=0x7FFFFFFF, b=1 -> next cycle r=0x80000000, overflow=1, zero=0. ADDU with the same operands -> overflow=0. SUB a=5, b=5 -> zero=1.
- SRA a=4, b=0x80000000 -> r=0xF8000000. SRL with the same operands -> 0x08000000. SLL a=0x21 (amount 1), b=1 -> r=2. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0.
- MULT a=-3, b=7 accepted in cycle N -> in_ready=0 for cycles N+1..N+33; out_valid in cycle N+34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB, r=lo. in_valid during busy is ignored.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Assert rst at cycle N+10 of a DIVU -> all outputs 0 immediately; no out_valid afterward. Release rst, issue ADD 1+2 -> r=3 one cycle later.
- WIDTH=8, MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 at N+10. Back-to-back issue of AND, OR, XOR -> three consecutive out_valid pulses with correct results.
